ro_puf_sequencer: RTL

// - Runs one measurement on a selected pair out of N_RO ring oscillators, each gated by its own enable.
// - Enables the pair and waits a settle time. Counts rising edges of both ROs over a fixed clk window.
// - Compares the two counts and returns one response bit plus the raw counts.
// - Sits between the challenge/response host logic and the RO bank.

---
 rtl/ro_puf_pkg.sv | 24 ++
 rtl/ro_puf_sequencer_edge_counter.sv | 58 +++++
 rtl/ro_puf_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator PUF sequencer.
//   state_e    : sequencer states, IDLE..DONE
//   STATE_W    : width of the state encoding
//   DRAIN_CYC  : cycles spent dropping in-flight synchroniser edges
//   cnt_max()  : all-ones value of a counter of the given width
package ro_puf_pkg;

  localparam int STATE_W   = 3;
  localparam int DRAIN_CYC = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_CMP     = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  function automatic logic [31:0] cnt_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/ro_puf_sequencer_edge_counter.sv
// One side of the measurement: 2-flop synchroniser on a raw RO output,
// rising-edge detect, and a saturating edge counter.
//   clk, rst_n : system clock, async active-low reset
//   clr        : zero the counter (start of a measurement)
//   cnt_en     : count window open
//   frz        : hold the count (either side saturated)
//   ro_in      : raw RO output, asynchronous to clk
//   cnt        : current edge count
//   at_max     : count is all-ones
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic             frz,
  input  logic             ro_in,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  // s3_q is the previous synchronised sample; rise is a one-cycle pulse.
  assign rise   = s2_q & ~s3_q;
  assign at_max = (cnt_q == CNT_MAX);
  assign cnt    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (cnt_en && rise && !frz && !at_max)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= ro_in;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ro_puf_sequencer.sv
// Ring-oscillator PUF measurement sequencer. Enables a selected RO pair,
// lets it settle, counts both ROs' rising edges over a fixed clk window,
// drains the synchronisers and returns one response bit plus raw counts.
//   start, sel_a, sel_b : request, selects latched on acceptance in IDLE
//   ro_out / ro_en      : RO bank outputs (async) / per-RO enables
//   busy, done          : in progress / one-cycle result strobe
//   resp, count_a/b     : count_a > count_b, final counts
//   sat, err            : a counter saturated / bad select, nothing measured
// Optional build macro ROPUF_TIE_FLAG_EN adds parameter TIE_THR and output
// tie, set with done when |count_a - count_b| <= TIE_THR.
module ro_puf_sequencer
  import ro_puf_pkg::*;
#(
  parameter int N_RO   = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 8,
  parameter int WINDOW = 1024
`ifdef ROPUF_TIE_FLAG_EN
  , parameter int TIE_THR = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SEL_W-1:0] sel_a,
  input  logic [SEL_W-1:0] sel_b,
  input  logic [N_RO-1:0]  ro_out,
  output logic [N_RO-1:0]  ro_en,
  output logic             busy,
  output logic             done,
  output logic             resp,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic             sat,
  output logic             err
`ifdef ROPUF_TIE_FLAG_EN
  , output logic           tie
`endif
);

  localparam int TMAX  = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int TMR_W = $clog2(TMAX) + 1;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [SEL_W-1:0] sela_q, sela_d, selb_q, selb_d;
  logic             clr, cnt_en, ld_res, ld_err, bad_sel;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic             max_a, max_b;
  logic             resp_q, sat_q, err_q;
  logic [CNT_W-1:0] count_a_q, count_b_q;

  assign bad_sel = (sel_a == sel_b) || (32'(sel_a) >= N_RO) || (32'(sel_b) >= N_RO);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    sela_d  = sela_q;
    selb_d  = selb_q;
    clr     = 1'b0;
    cnt_en  = 1'b0;
    ld_res  = 1'b0;
    ld_err  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        sela_d = sel_a;
        selb_d = sel_b;
        clr    = 1'b1;
        if (bad_sel) begin
          ld_err  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETTLE;
          tmr_d   = TMR_W'(SETTLE - 1);
        end
      end
      ST_SETTLE: if (tmr_q == '0) begin
        state_d = ST_MEASURE;
        tmr_d   = TMR_W'(WINDOW - 1);
      end else tmr_d = tmr_q - 1'b1;
      ST_MEASURE: begin
        cnt_en = 1'b1;
        if (tmr_q == '0) begin
          state_d = ST_DRAIN;
          tmr_d   = TMR_W'(DRAIN_CYC - 1);
        end else tmr_d = tmr_q - 1'b1;
      end
      ST_DRAIN: if (tmr_q == '0) state_d = ST_CMP;
                else tmr_d = tmr_q - 1'b1;
      ST_CMP: begin
        ld_res  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      sela_q  <= '0;
      selb_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      sela_q  <= sela_d;
      selb_q  <= selb_d;
    end
  end

  // Decoded from the async-reset state so the enables drop the moment rst_n falls.
  always_comb begin
    ro_en = '0;
    if (state_q == ST_SETTLE || state_q == ST_MEASURE) begin
      ro_en[sela_q] = 1'b1;
      ro_en[selb_q] = 1'b1;
    end
  end

  // Saturation of either side freezes both, keeping the pair comparable.
  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cnt_en(cnt_en), .frz(max_a | max_b),
    .ro_in(ro_out[sela_q]), .cnt(cnt_a), .at_max(max_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cnt_en(cnt_en), .frz(max_a | max_b),
    .ro_in(ro_out[selb_q]), .cnt(cnt_b), .at_max(max_b)
  );

  // Results change only on the cycle before done, so they hold between runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q    <= 1'b0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
      count_a_q <= '0;
      count_b_q <= '0;
    end else if (ld_err) begin
      resp_q    <= 1'b0;
      sat_q     <= 1'b0;
      err_q     <= 1'b1;
      count_a_q <= '0;
      count_b_q <= '0;
    end else if (ld_res) begin
      resp_q    <= (cnt_a > cnt_b);
      sat_q     <= max_a | max_b;
      err_q     <= 1'b0;
      count_a_q <= cnt_a;
      count_b_q <= cnt_b;
    end
  end

`ifdef ROPUF_TIE_FLAG_EN
  logic [CNT_W:0] diff;
  logic           tie_q;
  assign diff = (cnt_a >= cnt_b) ? ({1'b0, cnt_a} - {1'b0, cnt_b})
                                 : ({1'b0, cnt_b} - {1'b0, cnt_a});
  // A rejected select made no measurement, so it never reports a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      tie_q <= 1'b0;
    else if (ld_err) tie_q <= 1'b0;
    else if (ld_res) tie_q <= (int'(diff) <= TIE_THR);
  end
  assign tie = tie_q;
`endif

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign resp    = resp_q;
  assign sat     = sat_q;
  assign err     = err_q;
  assign count_a = count_a_q;
  assign count_b = count_b_q;

endmodule
